// File: rtl/nco_pkg.sv
// Shared definitions for the sine NCO: widths, FCW-holding FSM states,
// quadrant encoding and the quarter-wave phase fold.
package nco_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int QPH_W     = 16;
  localparam int SAMPLE_W  = 17;

  typedef enum logic {
    FCW_EMPTY,
    FCW_PENDING
  } fcw_state_e;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  typedef struct packed {
    logic [QPH_W-1:0] qph;
    logic             sign;
  } fold_t;

  // Map the top 18 phase bits onto a 0..90 degree phase plus a sign.
  // Odd quadrants run backwards through the quarter wave; the lower half
  // of the circle is negated.
  function automatic fold_t fold_phase(input logic [QPH_W+1:0] top);
    fold_t            r;
    quad_e            quad;
    logic [QPH_W-1:0] frac;
    quad = quad_e'(top[QPH_W+1:QPH_W]);
    frac = top[QPH_W-1:0];
    case (quad)
      QUAD_0:  begin r.qph = frac;  r.sign = 1'b0; end
      QUAD_1:  begin r.qph = ~frac; r.sign = 1'b0; end
      QUAD_2:  begin r.qph = frac;  r.sign = 1'b1; end
      default: begin r.qph = ~frac; r.sign = 1'b1; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sine_nco.sv
// Sine NCO: phase accumulator with a double-buffered frequency word and a
// sync-to-zero request, folding each phase into a quarter-wave address for
// an external cordic and re-applying the sign to the returned magnitude.
module sine_nco
  import nco_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [ACC_W-1:0]           i_fcw,
  input  logic                       i_fcw_valid,
  output logic                       o_fcw_ready,
  input  logic                       i_sync,
  output logic [QPH_W-1:0]           o_qph,
  input  logic [QPH_W-1:0]           i_sin,
  output logic signed [SAMPLE_W-1:0] o_sample,
  output logic                       o_valid,
  input  logic                       i_ready
);

  fcw_state_e                 fcw_state_q;
  logic                       fcw_ready_q;
  logic [ACC_W-1:0]           fcw_hold_q;
  logic [ACC_W-1:0]           fcw_active_q;
  logic [ACC_W-1:0]           acc_q;
  logic [ACC_W-1:0]           acc_d;
  logic                       sync_q;
  logic                       v1_q;
  logic [QPH_W-1:0]           qph_q;
  logic                       sign_q;
  logic                       valid_q;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic signed [SAMPLE_W-1:0] sample_d;

  logic                       advance;
  logic                       fire;
  logic                       apply;
  logic [ACC_W-1:0]           fcw_eff;
  logic [ACC_W-1:0]           phase;
  logic signed [SAMPLE_W-1:0] mag;
  fold_t                      fold_now;

  // Stall control, effective increment and the phase used for this sample.
  // A word applied this cycle already drives this cycle's increment, and a
  // pending sync replaces the accumulator with zero for the issued sample.
  always_comb begin
    advance  = !valid_q || i_ready;
    fire     = advance && i_en;
    apply    = fire && (fcw_state_q == FCW_PENDING);
    fcw_eff  = apply ? fcw_hold_q : fcw_active_q;
    phase    = sync_q ? '0 : acc_q;
    acc_d    = phase + fcw_eff;
    fold_now = fold_phase(phase[ACC_W-1 -: QPH_W+2]);
    mag      = signed'({1'b0, i_sin});
    sample_d = sign_q ? -mag : mag;
  end

  // FCW holding register: accept one word when empty, hand it over on the
  // next sample issue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fcw_state_q  <= FCW_EMPTY;
      fcw_ready_q  <= 1'b1;
      fcw_hold_q   <= '0;
      fcw_active_q <= '0;
    end else begin
      case (fcw_state_q)
        FCW_EMPTY: begin
          if (i_fcw_valid) begin
            fcw_hold_q  <= i_fcw;
            fcw_state_q <= FCW_PENDING;
            fcw_ready_q <= 1'b0;
          end
        end
        default: begin
          if (fire) begin
            fcw_active_q <= fcw_hold_q;
            fcw_state_q  <= FCW_EMPTY;
            fcw_ready_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Sticky sync request, consumed by the next issued sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= (fire ? 1'b0 : sync_q) | i_sync;
    end
  end

  // Stage 1: advance the accumulator and register the folded phase.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q  <= '0;
      v1_q   <= 1'b0;
      qph_q  <= '0;
      sign_q <= 1'b0;
    end else if (advance) begin
      v1_q <= i_en;
      if (i_en) begin
        acc_q  <= acc_d;
        qph_q  <= fold_now.qph;
        sign_q <= fold_now.sign;
      end
    end
  end

  // Stage 2: sign the cordic magnitude and present it downstream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      sample_q <= '0;
    end else if (advance) begin
      valid_q  <= v1_q;
      sample_q <= sample_d;
    end
  end

  assign o_fcw_ready = fcw_ready_q;
  assign o_qph       = qph_q;
  assign o_sample    = sample_q;
  assign o_valid     = valid_q;

endmodule

// File: tb/tb_sine_nco.sv
// Bench for sine_nco: a stand-in cordic (magnitude equals the quarter
// phase) closes the loop; a transaction-level model tracks phase, FCW and
// sync behaviour and predicts every output each cycle.
module tb_sine_nco;

  localparam int     ACC_W = 32;
  localparam longint MODV  = 64'h1_0000_0000;

  logic               clk;
  logic               rst;
  logic               en;
  logic [ACC_W-1:0]   fcw;
  logic               fcw_valid;
  logic               fcw_ready;
  logic               sync;
  logic [15:0]        qph;
  logic [15:0]        sin_mag;
  logic signed [16:0] sample;
  logic               valid;
  logic               ready;

  sine_nco #(.ACC_W(ACC_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_fcw       (fcw),
    .i_fcw_valid (fcw_valid),
    .o_fcw_ready (fcw_ready),
    .i_sync      (sync),
    .o_qph       (qph),
    .i_sin       (sin_mag),
    .o_sample    (sample),
    .o_valid     (valid),
    .i_ready     (ready)
  );

  assign sin_mag = qph;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state
  longint m_acc, m_active, m_hold, m_ph, m_sample;
  bit     m_pending, m_sync, m_v1, m_valid;

  function automatic longint exp_qph(input longint ph);
    longint top, quad, frac;
    top  = ph / (longint'(1) << (ACC_W - 18));
    quad = top / 65536;
    frac = top % 65536;
    return (quad % 2 == 1) ? 65535 - frac : frac;
  endfunction

  function automatic longint exp_sample(input longint ph);
    longint quad, mag;
    quad = (ph / (longint'(1) << (ACC_W - 18))) / 65536;
    mag  = exp_qph(ph);
    return (quad >= 2) ? -mag : mag;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_active = 0; m_hold = 0; m_ph = 0; m_sample = 0;
    m_pending = 0; m_sync = 0; m_v1 = 0; m_valid = 0;
  endtask

  task automatic model_edge();
    bit     adv, fire, apply;
    longint eff, ph;
    adv   = !m_valid || ready;
    fire  = adv && en;
    apply = fire && m_pending;
    eff   = apply ? m_hold : m_active;
    if (adv) begin
      m_sample = exp_sample(m_ph);
      m_valid  = m_v1;
      m_v1     = en;
    end
    if (fire) begin
      ph    = m_sync ? 0 : m_acc;
      m_ph  = ph;
      m_acc = (ph + eff) % MODV;
    end
    m_sync = (fire ? 1'b0 : m_sync) || sync;
    if (!m_pending) begin
      if (fcw_valid) begin
        m_hold    = longint'(fcw);
        m_pending = 1;
      end
    end else if (apply) begin
      m_active  = m_hold;
      m_pending = 0;
    end
  endtask

  task automatic compare_all();
    check("valid", longint'(valid), longint'(m_valid));
    check("fcw_ready", longint'(fcw_ready), longint'(!m_pending));
    if (m_valid) check("sample", longint'(sample), m_sample);
    if (m_v1) check("qph", longint'(qph), exp_qph(m_ph));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid", longint'(valid), 0);
    check("rst_fcw_ready", longint'(fcw_ready), 1);
    check("rst_qph", longint'(qph), 0);
    check("rst_sample", longint'(sample), 0);
    #1;
    rst = 1'b0;
  endtask

  longint seq_exp [4] = '{0, 65535, 0, -65535};
  longint got_s;
  int     k;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; en = 1'b0; fcw = '0; fcw_valid = 1'b0; sync = 1'b0; ready = 1'b1;
    #1;
    model_reset();
    check("init_valid", longint'(valid), 0);
    check("init_fcw_ready", longint'(fcw_ready), 1);
    check("init_qph", longint'(qph), 0);
    check("init_sample", longint'(sample), 0);
    @(negedge clk);
    rst = 1'b0;

    // Quarter-turn stream with explicit latency and value checks
    fcw = 32'h4000_0000; fcw_valid = 1'b1;
    tick();
    fcw_valid = 1'b0; en = 1'b1;
    tick();
    check("latency_1cyc", longint'(valid), 0);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) check("latency_2cyc", longint'(valid), 1);
      if (valid) begin
        got_s = longint'(sample);
        check("quarter_seq", got_s, seq_exp[k % 4]);
        k++;
      end
    end

    // Downstream stall mid-stream
    ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // New word while running, then sync
    fcw = 32'h2000_0000; fcw_valid = 1'b1;
    tick();
    fcw_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Reset with sample in flight and a word pending, then FCW=0 restart
    fcw = 32'h1234_5678; fcw_valid = 1'b1;
    tick();
    fcw_valid = 1'b0;
    pulse_reset();
    for (int i = 0; i < 6; i++) tick();

    // en toggling 1,0,1 with a fresh word
    en = 1'b0;
    pulse_reset();
    fcw = 32'h0100_0000; fcw_valid = 1'b1;
    tick();
    fcw_valid = 1'b0;
    en = 1'b1; tick();
    en = 1'b0; tick();
    en = 1'b1; tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      en        = ($urandom % 4) != 0;
      ready     = ($urandom % 3) != 0;
      fcw_valid = ($urandom % 8) == 0;
      fcw       = $urandom;
      sync      = ($urandom % 16) == 0;
      if (($urandom % 600) == 0) pulse_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sine_nco.md
SINE_NCO -- requirements
Module: sine_nco

Interface
REQ-001 SHALL have parameter ACC_W, default 32, phase accumulator width; legal range 18..48.
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port i_en  input  1  request one new phase sample per advancing cycle.
REQ-005 SHALL have port i_fcw  input  ACC_W  frequency control word, unsigned phase increment.
REQ-006 SHALL have port i_fcw_valid  input  1  i_fcw offered.
REQ-007 SHALL have port o_fcw_ready  output  1  FCW holding register free.
REQ-008 SHALL have port i_sync  input  1  one-cycle pulse; zero accumulator at next advance.
REQ-009 SHALL have port o_qph  output  16  folded quarter phase, 0x0000=0 deg, 0xFFFF=90 deg, to cordic.
REQ-010 SHALL have port i_sin  input  16  unsigned quarter-wave magnitude returned by cordic for o_qph.
REQ-011 SHALL have port o_sample  output  17  signed two's-complement sine sample.
REQ-012 SHALL have port o_valid  output  1  o_sample valid.
REQ-013 SHALL have port i_ready  input  1  downstream accepts o_sample.

Function
REQ-014 SHALL define advance = !o_valid || i_ready; when advance=0, all pipeline and accumulator state SHALL hold.
REQ-015 On advance with i_en=1: v1<=1, register fold of acc into o_qph and sign bit, then acc<=acc+fcw_active mod 2^ACC_W; with i_en=0: v1<=0, acc holds.
REQ-016 On advance: o_valid<=v1, o_sample<=sign ? -{1'b0,i_sin} : {1'b0,i_sin}; latency from sampled i_en to o_valid is exactly 2 cycles without stall.
REQ-017 Fold SHALL use q=acc[ACC_W-1:ACC_W-2], f=acc[ACC_W-3:ACC_W-18]: q0 qph=f sign=0; q1 qph=~f sign=0; q2 qph=f sign=1; q3 qph=~f sign=1.
REQ-018 FCW FSM states EMPTY, PENDING: EMPTY with i_fcw_valid captures i_fcw into fcw_hold -> PENDING; o_fcw_ready=1 only in EMPTY.
REQ-019 PENDING -> EMPTY on next advance with i_en=1, fcw_active<=fcw_hold; that cycle's increment SHALL already use the new word.
REQ-020 i_sync SHALL set a sticky flag; on next advance with i_en=1 the sample SHALL use acc=0 and acc<=fcw_active(new if simultaneously applied); flag clears.
REQ-021 i_sync and FCW apply in same advance SHALL both take effect; i_sync while flag set SHALL be idempotent.
REQ-022 Accumulator wrap SHALL be silent modulo 2^ACC_W; no overflow indication.
REQ-023 o_sample SHALL be stable while o_valid=1 and i_ready=0.

Reset
REQ-024 While i_rst=1: acc=0, fcw_active=0, fcw_hold=0, FSM=EMPTY, sync flag=0, v1=0, o_valid=0, o_qph=0, o_sample=0, o_fcw_ready=1.
REQ-025 Reset asserted mid-stream SHALL discard in-flight samples and pending FCW; first post-reset sample uses acc=0.

Structure
REQ-026 Package nco_pkg SHALL hold ACC_W default, QPH_W=16, SAMPLE_W=17, FCW FSM state enum, quadrant enum.
REQ-027 Fold logic SHALL be a function in nco_pkg; no sub-module inside sine_nco; the existing cordic block SHALL be instantiated alongside by the integrating top, wired o_qph->i_qph, o_sin->i_sin.

Verification
REQ-028 FCW=0x40000000, i_en=1, i_ready=1, cordic attached -> o_qph 0x0000,0xFFFF,0x0000,0xFFFF; o_sample 0, 65535, 0, -65535 (0x10001), repeating; first o_valid 2 cycles after i_en.
REQ-029 Same stream, i_ready=0 for 5 cycles mid-stream -> o_sample held, no sample lost or duplicated, accumulator frozen.
REQ-030 FCW=0x40000000 running, offer 0x20000000 -> o_fcw_ready drops 1 cycle, subsequent o_qph sequence steps 0x8000 per sample from the current phase.
REQ-031 i_sync pulse at acc=0x80000000 -> next issued sample qph=0x0000 sign=0, following acc=fcw_active.
REQ-032 i_rst pulse with o_valid=1 and FCW pending -> o_valid=0, o_fcw_ready=1 immediately; restart with FCW=0 yields constant o_sample=0.
REQ-033 i_en toggling 1,0,1 -> exactly two o_valid pulses, consecutive phases acc=0 and acc=FCW.
